// File: rtl/c5x7_conv_if.sv
// Bus bundle for c5x7_conv: weight config port, 35-sample window push and result.
// Samples are indexed row*5+col (samp[0] = samp00, samp[34] = samp64).
interface c5x7_conv_if #(
   parameter int DATA_W = 40,
   parameter int COEF_W = 33,
   parameter int RES_W  = 45
);
   logic [5:0]               ca;
   logic signed [COEF_W-1:0] cd;
   logic                     cw;
   logic                     push_samp;
   logic signed [DATA_W-1:0] samp [35];
   logic                     pushout;
   logic signed [RES_W-1:0]  res;

   modport master (output ca, cd, cw, push_samp, samp, input pushout, res);
   modport slave  (input ca, cd, cw, push_samp, samp, output pushout, res);
endinterface

// File: rtl/c5x7_conv.sv
// 5x7 2-D convolution kernel: 35 signed taps, 6-clock fixed latency, one window per clock.
// Optional macro C5X7_SAT_EN saturates the result instead of wrapping it.
module c5x7_conv #(
   parameter int DATA_W = 40,
   parameter int COEF_W = 33,
   parameter int RES_W  = 45,
   parameter int FRAC   = 24
) (
   input logic         clk,
   input logic         reset,
   c5x7_conv_if.slave  bus
);
   localparam int NTAP  = 35;
   localparam int NROW  = 7;
   localparam int NCOL  = 5;
   localparam int SPLIT = 16;
   localparam int LO_W  = DATA_W + SPLIT + 1;
   localparam int HI_W  = DATA_W + COEF_W - SPLIT;
   localparam int SUM_W = DATA_W + COEF_W + 6;

   function automatic logic signed [RES_W-1:0] shape_res(input logic signed [SUM_W-1:0] s);
`ifdef C5X7_SAT_EN
      logic signed [SUM_W-1:0] sh;
      sh = s >>> FRAC;
      if (&sh[SUM_W-1:RES_W-1] || ~|sh[SUM_W-1:RES_W-1])
         return sh[RES_W-1:0];
      return sh[SUM_W-1] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
`else
      return RES_W'(s >>> FRAC);
`endif
   endfunction

   logic signed [COEF_W-1:0] weight_q [NTAP];
   logic signed [COEF_W-1:0] weight_d [NTAP];

   // weight_d doubles as the bypassed tap set for a window pushed in the same cycle
   always_comb begin
      for (int i = 0; i < NTAP; i++) begin
         weight_d[i] = weight_q[i];
         if (bus.cw && bus.ca == 6'(i))
            weight_d[i] = bus.cd;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NTAP; i++) begin
         if (!reset) weight_q[i] <= '0;
         else        weight_q[i] <= weight_d[i];
      end
   end

   logic signed [DATA_W-1:0] samp_p0 [NTAP];
   logic signed [COEF_W-1:0] w_p0    [NTAP];
   logic signed [LO_W-1:0]   lo_p1   [NTAP];
   logic signed [HI_W-1:0]   hi_p1   [NTAP];
   logic signed [SUM_W-1:0]  row_d   [NROW];
   logic signed [SUM_W-1:0]  row_p2  [NROW];
   logic signed [SUM_W-1:0]  pair_p3 [4];
   logic signed [SUM_W-1:0]  quad_p4 [2];
   logic signed [SUM_W-1:0]  sum_p5;
   logic vld_p0, vld_p1, vld_p2, vld_p3, vld_p4, vld_p5;
   logic pushout_q;
   logic signed [RES_W-1:0]  res_q;

   always_ff @(posedge clk) begin
      if (bus.push_samp) begin
         for (int i = 0; i < NTAP; i++) begin
            samp_p0[i] <= bus.samp[i];
            w_p0[i]    <= weight_d[i];
         end
      end
   end

   // Each tap multiply is split into a 17-bit unsigned low slice and a signed high slice
   always_ff @(posedge clk) begin
      for (int i = 0; i < NTAP; i++) begin
         lo_p1[i] <= LO_W'(samp_p0[i]) * LO_W'($signed({1'b0, w_p0[i][SPLIT-1:0]}));
         hi_p1[i] <= HI_W'(samp_p0[i]) * HI_W'($signed(w_p0[i][COEF_W-1:SPLIT]));
      end
   end

   always_comb begin
      for (int r = 0; r < NROW; r++) begin
         row_d[r] = '0;
         for (int c = 0; c < NCOL; c++)
            row_d[r] = row_d[r] + (SUM_W'(hi_p1[r*NCOL+c]) <<< SPLIT) + SUM_W'(lo_p1[r*NCOL+c]);
      end
   end

   always_ff @(posedge clk) begin
      for (int r = 0; r < NROW; r++)
         row_p2[r] <= row_d[r];
      pair_p3[0] <= row_p2[0] + row_p2[1];
      pair_p3[1] <= row_p2[2] + row_p2[3];
      pair_p3[2] <= row_p2[4] + row_p2[5];
      pair_p3[3] <= row_p2[6];
      quad_p4[0] <= pair_p3[0] + pair_p3[1];
      quad_p4[1] <= pair_p3[2] + pair_p3[3];
      sum_p5     <= quad_p4[0] + quad_p4[1];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         vld_p2    <= 1'b0;
         vld_p3    <= 1'b0;
         vld_p4    <= 1'b0;
         vld_p5    <= 1'b0;
         pushout_q <= 1'b0;
         res_q     <= '0;
      end else begin
         vld_p0    <= bus.push_samp;
         vld_p1    <= vld_p0;
         vld_p2    <= vld_p1;
         vld_p3    <= vld_p2;
         vld_p4    <= vld_p3;
         vld_p5    <= vld_p4;
         pushout_q <= vld_p5;
         if (vld_p5)
            res_q <= shape_res(sum_p5);
      end
   end

   assign bus.pushout = pushout_q;
   assign bus.res     = res_q;
endmodule

// File: tb/tb_c5x7_conv.sv
// Self-checking bench for c5x7_conv: directed cases plus randomized traffic against a
// queue-based reference that computes each window's weighted sum directly.
module tb_c5x7_conv;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   c5x7_conv_if bus();
   c5x7_conv dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic armed = 1'b0;
   logic signed [32:0] wm [35];
   int          due_q [$];
   logic [44:0] val_q [$];
   logic        exp_po = 1'b0;
   logic [44:0] exp_res = '0;
   int          n_po = 0;
   logic [44:0] last_res = '0;
   int          last_po_cyc = 0;

   task automatic chk(input string name, input logic [44:0] act, input logic [44:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [44:0] ref_res(input logic signed [127:0] s);
      logic signed [127:0] sh;
      sh = s >>> 24;
`ifdef C5X7_SAT_EN
      if (sh > 128'sd17592186044415)  return 45'h0FFFFFFFFFFF;
      if (sh < -128'sd17592186044416) return 45'h100000000000;
`endif
      return sh[44:0];
   endfunction

   // Reference: every accepted window is summed at full precision and scheduled 6 edges later
   always @(posedge clk) begin
      logic signed [127:0] s;
      logic signed [32:0]  w;
      cyc = cyc + 1;
      if (!reset) begin
         armed = 1'b1;
         for (int i = 0; i < 35; i++) wm[i] = '0;
         due_q.delete();
         val_q.delete();
         exp_po  = 1'b0;
         exp_res = '0;
      end else begin
         exp_po = 1'b0;
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            exp_po  = 1'b1;
            exp_res = val_q.pop_front();
            void'(due_q.pop_front());
         end
         if (bus.push_samp) begin
            s = '0;
            for (int i = 0; i < 35; i++) begin
               w = (bus.cw && int'(bus.ca) == i) ? bus.cd : wm[i];
               s = s + 128'(bus.samp[i]) * 128'(w);
            end
            due_q.push_back(cyc + 6);
            val_q.push_back(ref_res(s));
         end
         if (bus.cw && bus.ca < 6'd35) wm[bus.ca] = bus.cd;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("pushout", 45'(bus.pushout), 45'(exp_po));
         chk("res", bus.res, exp_res);
         if (bus.pushout) begin
            n_po++;
            last_res    = bus.res;
            last_po_cyc = cyc;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         bus.push_samp = 1'b0;
         bus.cw        = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic wr(input int a, input logic [32:0] d);
      bus.push_samp = 1'b0;
      bus.cw        = 1'b1;
      bus.ca        = 6'(a);
      bus.cd        = d;
      @(negedge clk);
      bus.cw = 1'b0;
   endtask

   task automatic push1();
      bus.cw        = 1'b0;
      bus.push_samp = 1'b1;
      @(negedge clk);
      bus.push_samp = 1'b0;
   endtask

   task automatic do_reset();
      bus.push_samp = 1'b0;
      bus.cw        = 1'b0;
      reset         = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic rand_samples();
      logic [63:0] t;
      for (int i = 0; i < 35; i++) begin
         t = {$urandom(), $urandom()};
         bus.samp[i] = t[39:0];
      end
   endtask

   initial begin
      int t0;
      int n0;
      logic [63:0] t;
      reset = 1'b0;
      bus.push_samp = 1'b0;
      bus.cw = 1'b0;
      bus.ca = '0;
      bus.cd = '0;
      for (int i = 0; i < 35; i++) bus.samp[i] = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Idle after reset
      idle(10);
      chk("t1_pushouts", 45'(n_po), 45'd0);
      chk("t1_res", bus.res, 45'd0);

      // Single tap of 1.0 on samp00
      wr(0, 33'h1000000);
      rand_samples();
      bus.samp[0] = 40'd100;
      n0 = n_po;
      push1();
      t0 = cyc;
      idle(10);
      chk("t2_count", 45'(n_po - n0), 45'd1);
      chk("t2_res", last_res, 45'd100);
      chk("t2_latency", 45'(last_po_cyc - t0), 45'd6);

      // All taps 1.0, all samples -1, back-to-back
      for (int i = 0; i < 35; i++) wr(i, 33'h1000000);
      for (int i = 0; i < 35; i++) bus.samp[i] = '1;
      n0 = n_po;
      repeat (40) begin
         bus.cw = 1'b0;
         bus.push_samp = 1'b1;
         @(negedge clk);
      end
      idle(10);
      chk("t3_count", 45'(n_po - n0), 45'd40);
      chk("t3_res", last_res, 45'h1FFFFFFFFFDD);

      // Write bypass into the same window, then the stored weight on a later push
      do_reset();
      rand_samples();
      bus.samp[34] = 40'd7;
      n0 = n_po;
      bus.cw = 1'b1;
      bus.ca = 6'd34;
      bus.cd = 33'h2000000;
      bus.push_samp = 1'b1;
      @(negedge clk);
      idle(10);
      chk("t4_bypass_res", last_res, 45'd14);
      rand_samples();
      bus.samp[34] = 40'd7;
      push1();
      idle(10);
      chk("t4_stored_res", last_res, 45'd14);
      chk("t4_count", 45'(n_po - n0), 45'd2);

      // Reset with three windows in flight
      do_reset();
      wr(0, 33'h1000000);
      rand_samples();
      bus.samp[0] = 40'd5;
      bus.cw = 1'b0;
      bus.push_samp = 1'b1;
      repeat (3) @(negedge clk);
      n0 = n_po;
      do_reset();
      idle(10);
      chk("t5_no_pushout", 45'(n_po - n0), 45'd0);
      push1();
      idle(10);
      chk("t5_count", 45'(n_po - n0), 45'd1);
      chk("t5_res", last_res, 45'd0);

      // Overflow of the RW-bit result
      do_reset();
      wr(0, 33'h0FFFFFFFF);
      rand_samples();
      bus.samp[0] = 40'h7FFFFFFFFF;
      repeat (3) push1();
      idle(10);
`ifdef C5X7_SAT_EN
      chk("t6_sat_res", last_res, 45'h0FFFFFFFFFFF);
`else
      chk("t6_wrap_res", last_res, 45'h1FFFFFFF7F00);
`endif

      // Randomized traffic: writes (including out-of-range addresses), pushes, rare resets
      repeat (3000) begin
         rand_samples();
         t = {$urandom(), $urandom()};
         bus.cd = ($urandom_range(0, 3) == 0) ? t[32:0] : 33'(signed'(t[26:0]));
         bus.ca = 6'($urandom_range(0, 40));
         bus.cw = ($urandom_range(0, 3) == 0);
         bus.push_samp = ($urandom_range(0, 9) < 7);
         reset = ($urandom_range(0, 199) != 0);
         @(negedge clk);
      end
      reset = 1'b1;
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
